// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and load-enable control for the fetch-stage
// program counter register. Sequences the boot/reset-vector load, sequential
// fetch, stalls, and trap/mret/branch redirects, parking a redirect that
// arrives while instruction memory is still busy with the current fetch.
//
// Optional build macro MISALIGN_TRAP_EN: when defined, a branch or mret
// redirect to a non-word-aligned address is refused and reported on MisalignF
// so the CSR logic can raise a trap. When undefined, redirect addresses are
// loaded with bits [1:0] forced to zero.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned BOOT_CYCLES  = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] PCF,
   input  logic        StallF,
   input  logic        IMemReady,
   input  logic        BranchTakenE,
   input  logic [31:0] PCTargetE,
   input  logic        TrapReq,
   input  logic [31:0] MtvecBase,
   input  logic        MretReq,
   input  logic [31:0] MepcVal,
   output logic [31:0] PCF_p,
   output logic        EN,
   output logic        FlushD,
   output logic        FlushE,
`ifdef MISALIGN_TRAP_EN
   output logic        Busy,
   output logic        MisalignF
`else
   output logic        Busy
`endif
);

   typedef enum logic [1:0] {BOOT, LOAD, RUN, PEND} state_t;

   // Kind encoding doubles as priority: a larger value wins.
   typedef enum logic [1:0] {
      KIND_NONE   = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_MRET   = 2'd2,
      KIND_TRAP   = 2'd3
   } kind_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  bootCnt_q, bootCnt_d;
   logic        pendValid_q, pendValid_d;
   logic [31:0] pendAddr_q, pendAddr_d;
   kind_t       pendKind_q, pendKind_d;

   kind_t       reqKind;
   logic [31:0] reqAddr;
   kind_t       selKind;
   logic [31:0] selAddr;
   logic        doRedirect;
   kind_t       rdKind;
   logic [31:0] rdAddr;

   // Pick the highest-priority redirect requested this cycle and its address.
   always_comb begin
      reqKind = KIND_NONE;
      reqAddr = PCTargetE;
      if (TrapReq) begin
         reqKind = KIND_TRAP;
         reqAddr = {MtvecBase[31:2], 2'b00};
      end else if (MretReq) begin
         reqKind = KIND_MRET;
         reqAddr = MepcVal;
      end else if (BranchTakenE) begin
         reqKind = KIND_BRANCH;
         reqAddr = PCTargetE;
      end
   end

   // Next-state and output decode; redirect outputs are applied after the case.
   always_comb begin
      state_d     = state_q;
      bootCnt_d   = bootCnt_q;
      pendValid_d = pendValid_q;
      pendAddr_d  = pendAddr_q;
      pendKind_d  = pendKind_q;
      PCF_p       = PCF + 32'd4;
      EN          = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      Busy        = 1'b0;
      selKind     = pendKind_q;
      selAddr     = pendAddr_q;
      doRedirect  = 1'b0;
      rdKind      = KIND_NONE;
      rdAddr      = reqAddr;
`ifdef MISALIGN_TRAP_EN
      MisalignF   = 1'b0;
`endif

      case (state_q)
         BOOT: begin
            PCF_p     = RESET_VECTOR;
            Busy      = 1'b1;
            bootCnt_d = bootCnt_q + 4'd1;
            if (bootCnt_q == BOOT_LAST) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            PCF_p   = RESET_VECTOR;
            EN      = 1'b1;
            FlushD  = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (reqKind != KIND_NONE) begin
               if (IMemReady) begin
                  doRedirect = 1'b1;
                  rdKind     = reqKind;
                  rdAddr     = reqAddr;
               end else begin
                  pendValid_d = 1'b1;
                  pendAddr_d  = reqAddr;
                  pendKind_d  = reqKind;
                  state_d     = PEND;
               end
            end else begin
               EN = IMemReady & ~StallF;
            end
         end
         PEND: begin
            if (reqKind > pendKind_q) begin
               selKind = reqKind;
               selAddr = reqAddr;
            end
            if (IMemReady) begin
               doRedirect  = 1'b1;
               rdKind      = selKind;
               rdAddr      = selAddr;
               pendValid_d = 1'b0;
               state_d     = RUN;
            end else begin
               Busy       = pendValid_q;
               pendAddr_d = selAddr;
               pendKind_d = selKind;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      if (doRedirect) begin
`ifdef MISALIGN_TRAP_EN
         if ((rdKind != KIND_TRAP) && (rdAddr[1:0] != 2'b00)) begin
            EN        = 1'b0;
            FlushD    = 1'b1;
            MisalignF = 1'b1;
         end else begin
            EN     = 1'b1;
            PCF_p  = {rdAddr[31:2], 2'b00};
            FlushD = 1'b1;
            FlushE = (rdKind == KIND_TRAP) || (rdKind == KIND_MRET);
         end
`else
         EN     = 1'b1;
         PCF_p  = {rdAddr[31:2], 2'b00};
         FlushD = 1'b1;
         FlushE = (rdKind == KIND_TRAP) || (rdKind == KIND_MRET);
`endif
      end
   end

   // State, boot counter and parked-redirect registers; reset restarts boot.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= BOOT;
         bootCnt_q   <= 4'd0;
         pendValid_q <= 1'b0;
         pendAddr_q  <= 32'd0;
         pendKind_q  <= KIND_NONE;
      end else begin
         state_q     <= state_d;
         bootCnt_q   <= bootCnt_d;
         pendValid_q <= pendValid_d;
         pendAddr_q  <= pendAddr_d;
         pendKind_q  <= pendKind_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a directed driver pushes hand-computed expected
// outputs into a queue each cycle, and an independent monitor pops and
// compares them against the DUT on the falling edge.
module tb_pc_sequencer;

   typedef struct {
      string       name;
      logic        en;
      logic [31:0] pc;
      logic        chkPc;
      logic        fd;
      logic        fe;
      logic        busy;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] PCF;
   logic        StallF;
   logic        IMemReady;
   logic        BranchTakenE;
   logic [31:0] PCTargetE;
   logic        TrapReq;
   logic [31:0] MtvecBase;
   logic        MretReq;
   logic [31:0] MepcVal;
   logic [31:0] PCF_p;
   logic        EN;
   logic        FlushD;
   logic        FlushE;
   logic        Busy;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   pc_sequencer #(
      .RESET_VECTOR(32'h0000_0100),
      .BOOT_CYCLES (2)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .PCF         (PCF),
      .StallF      (StallF),
      .IMemReady   (IMemReady),
      .BranchTakenE(BranchTakenE),
      .PCTargetE   (PCTargetE),
      .TrapReq     (TrapReq),
      .MtvecBase   (MtvecBase),
      .MretReq     (MretReq),
      .MepcVal     (MepcVal),
      .PCF_p       (PCF_p),
      .EN          (EN),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .Busy        (Busy)
   );

   // Free-running 10-unit clock.
   always #5 CLK = ~CLK;

   // Compare one expected entry against the DUT outputs.
   task automatic checkOutput(input exp_t e);
      logic ok;
      ok = (EN === e.en) && (FlushD === e.fd) && (FlushE === e.fe) && (Busy === e.busy);
      if (e.chkPc && (PCF_p !== e.pc)) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s: got EN=%b PCF_p=%h FlushD=%b FlushE=%b Busy=%b, want EN=%b PCF_p=%h(chk=%b) FlushD=%b FlushE=%b Busy=%b",
                  e.name, EN, PCF_p, FlushD, FlushE, Busy, e.en, e.pc, e.chkPc, e.fd, e.fe, e.busy);
      end
   endtask

   // Monitor: whenever an expectation is queued, check it mid-cycle.
   always @(negedge CLK) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   // Queue the expected outputs for the current cycle, then advance one cycle.
   task automatic applyStimulus(input string name, input logic en, input logic [31:0] pc,
                                input logic chkPc, input logic fd, input logic fe,
                                input logic busy);
      exp_t e;
      e.name  = name;
      e.en    = en;
      e.pc    = pc;
      e.chkPc = chkPc;
      e.fd    = fd;
      e.fe    = fe;
      e.busy  = busy;
      expQ.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic idleCycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic clearReq();
      BranchTakenE = 1'b0;
      TrapReq      = 1'b0;
      MretReq      = 1'b0;
   endtask

   // Directed stimulus sequence.
   initial begin
      RST          = 1'b1;
      PCF          = 32'h0;
      StallF       = 1'b0;
      IMemReady    = 1'b1;
      BranchTakenE = 1'b0;
      PCTargetE    = 32'h0;
      TrapReq      = 1'b0;
      MtvecBase    = 32'h0;
      MretReq      = 1'b0;
      MepcVal      = 32'h0;
      idleCycle();

      // Reset held: BOOT outputs.
      applyStimulus("rstHold1", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus("rstHold2", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      RST = 1'b0;
      applyStimulus("boot1", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus("boot2", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus("load", 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
      PCF = 32'h100;
      applyStimulus("seq104", 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
      PCF = 32'h104;
      applyStimulus("seq108", 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);

      // Stall holds the PC.
      PCF = 32'h200;
      StallF = 1'b1;
      applyStimulus("stall1", 1'b0, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus("stall2", 1'b0, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
      StallF = 1'b0;
      applyStimulus("unstall", 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);

      // Trap beats branch, mtvec low bits ignored; stall ignored on redirect.
      StallF       = 1'b1;
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h400;
      TrapReq      = 1'b1;
      MtvecBase    = 32'h803;
      applyStimulus("trapPrio", 1'b1, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0);
      clearReq();
      StallF = 1'b0;

      // Mret beats branch.
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h600;
      MretReq      = 1'b1;
      MepcVal      = 32'h50;
      applyStimulus("mretPrio", 1'b1, 32'h50, 1'b1, 1'b1, 1'b1, 1'b0);
      clearReq();

      // Plain branch flushes D only.
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h600;
      applyStimulus("branch", 1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0);
      clearReq();

      // Mret to unaligned address is loaded with low bits cleared.
      MretReq = 1'b1;
      MepcVal = 32'h56;
      applyStimulus("mretAlign", 1'b1, 32'h54, 1'b1, 1'b1, 1'b1, 1'b0);
      clearReq();

      // Branch parked while memory busy for 3 cycles.
      PCF          = 32'h2F0;
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h300;
      IMemReady    = 1'b0;
      applyStimulus("park1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      clearReq();
      applyStimulus("park2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("park3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      IMemReady = 1'b1;
      applyStimulus("parkRel", 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
      PCF = 32'h300;
      applyStimulus("afterRel", 1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);

      // Parked branch overridden by mret.
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h700;
      IMemReady    = 1'b0;
      applyStimulus("ovParkB", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      clearReq();
      MretReq = 1'b1;
      MepcVal = 32'h50;
      applyStimulus("ovMretIn", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      clearReq();
      IMemReady = 1'b1;
      applyStimulus("ovMretRel", 1'b1, 32'h50, 1'b1, 1'b1, 1'b1, 1'b0);

      // Same-cycle trap override at release.
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h700;
      IMemReady    = 1'b0;
      applyStimulus("scParkB", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      clearReq();
      IMemReady = 1'b1;
      TrapReq   = 1'b1;
      MtvecBase = 32'h900;
      applyStimulus("scTrapRel", 1'b1, 32'h900, 1'b1, 1'b1, 1'b1, 1'b0);
      clearReq();

      // Lower-priority branch ignored while a trap is parked.
      TrapReq   = 1'b1;
      MtvecBase = 32'hA01;
      IMemReady = 1'b0;
      applyStimulus("loParkT", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      clearReq();
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h124;
      applyStimulus("loBrIgn", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      clearReq();
      IMemReady = 1'b1;
      applyStimulus("loTrapRel", 1'b1, 32'hA00, 1'b1, 1'b1, 1'b1, 1'b0);

      // Sequential wrap at the top of the address space.
      PCF = 32'hFFFF_FFFC;
      applyStimulus("wrap", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset while a redirect is parked discards it and reboots.
      PCF          = 32'h10;
      BranchTakenE = 1'b1;
      PCTargetE    = 32'h300;
      IMemReady    = 1'b0;
      applyStimulus("rpPark", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      clearReq();
      applyStimulus("rpPend", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      RST       = 1'b1;
      IMemReady = 1'b1;
      idleCycle();
      RST = 1'b0;
      applyStimulus("rpBoot1", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus("rpBoot2", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus("rpLoad", 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
      PCF = 32'h100;
      applyStimulus("rpRun", 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge CLK);
      end
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending entries, want 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
